// File: rtl/led_target_scorer_if.sv
`default_nettype none
// ============================================================================
// Module      : led_target_scorer_if
// Description : Control and display bundle between the game driver
//               (LFSR, tick generator, buttons) and the scorer core.
//               The master drives round control, target select and button
//               pulses. The slave (the scorer) drives LEDs, counters and state.
// Revision    : 1.0 - initial release
// ============================================================================
interface led_target_scorer_if #(
    parameter int NUM_LEDS = 3,
    parameter int SEL_W    = 2,
    parameter int SCORE_W  = 7,
    parameter int MISS_W   = 4
);
    logic                start;
    logic                change;
    logic [SEL_W-1:0]    rand_sel;
    logic [NUM_LEDS-1:0] btn;
    logic [NUM_LEDS-1:0] led;
    logic [SCORE_W-1:0]  score;
    logic [MISS_W-1:0]   misses;
    logic                game_over;
    logic [1:0]          state_o;

    modport master (
        output start, change, rand_sel, btn,
        input  led, score, misses, game_over, state_o
    );

    modport slave (
        input  start, change, rand_sel, btn,
        output led, score, misses, game_over, state_o
    );
endinterface
`default_nettype wire

// File: rtl/led_target_scorer.sv
`default_nettype none
// ============================================================================
// Module      : led_target_scorer
// Description : N-target reaction game core. Lights one target per change
//               pulse, scores hits, counts misses (expired or replaced
//               targets) and ends the round after MAX_MISSES misses.
//               Optional macro WRONG_PENALTY_EN: a wrong or unlit press in
//               RUN also counts as a miss and decrements the score.
// Revision    : 1.0 - initial release
// ============================================================================
module led_target_scorer #(
    parameter int NUM_LEDS    = 3,
    parameter int SEL_W       = 2,
    parameter int SCORE_W     = 7,
    parameter int MISS_W      = 4,
    parameter int TIMEOUT_CYC = 0,
    parameter int MAX_MISSES  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    led_target_scorer_if.slave   bus
);

    // The timer only needs to count 0 .. TIMEOUT_CYC-1.
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0]      TMO_LAST  = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [MISS_W-1:0]  MISS_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        OVER = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [MISS_W-1:0]   misses_q, misses_d;
    logic                over_q, over_d;
    logic [TW-1:0]       timer_q, timer_d;

    logic                hit;
    logic                expired;
    logic                replaced;
    logic                wrong;
    logic                miss;
    logic                sel_ok;
    logic [NUM_LEDS-1:0] led_new;

    // RUN events, all judged against the LED pattern lit before the edge.
    assign hit      = |(bus.btn & led_q);
    assign expired  = (led_q != '0) && (TIMEOUT_CYC != 0) && (timer_q == TMO_LAST) && !hit;
    assign replaced = bus.change && (led_q != '0) && !hit && !expired;
`ifdef WRONG_PENALTY_EN
    assign wrong    = (bus.btn != '0) && !hit;
`else
    assign wrong    = 1'b0;
`endif
    // A single miss flag keeps coincident events to one increment.
    assign miss     = expired || replaced || wrong;

    // Out-of-range selects (possible when NUM_LEDS is not a power of two) blank the LEDs.
    assign sel_ok   = (32'(bus.rand_sel) < NUM_LEDS);
    assign led_new  = sel_ok ? (NUM_LEDS'(1) << bus.rand_sel) : '0;

    // Next-state and next-output logic for the round FSM.
    always_comb begin
        state_d  = state_q;
        led_d    = led_q;
        score_d  = score_q;
        misses_d = misses_q;
        over_d   = over_q;
        timer_d  = timer_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                end
            end

            RUN: begin
                if (!bus.start) begin
                    // Stopping beats every game event in the same cycle.
                    state_d = HOLD;
                    led_d   = '0;
                    timer_d = '0;
                end else begin
                    if ((led_q != '0) && (TIMEOUT_CYC != 0)) begin
                        timer_d = timer_q + 1'b1;
                    end else begin
                        timer_d = '0;
                    end

                    if (hit) begin
                        led_d   = led_q & ~bus.btn;
                        timer_d = '0;
                        if (score_q != SCORE_MAX) begin
                            score_d = score_q + 1'b1;
                        end
                    end else if (wrong) begin
                        if (score_q != '0) begin
                            score_d = score_q - 1'b1;
                        end
                    end

                    if (expired) begin
                        led_d   = '0;
                        timer_d = '0;
                    end

                    if (miss && (misses_q != MISS_MAX)) begin
                        misses_d = misses_q + 1'b1;
                    end

                    // A new target overrides any clear from hit or expiry.
                    if (bus.change) begin
                        led_d   = led_new;
                        timer_d = '0;
                    end

                    if (miss && (MAX_MISSES != 0) && (32'(misses_d) == MAX_MISSES)) begin
                        state_d = OVER;
                        led_d   = '0;
                        timer_d = '0;
                        over_d  = 1'b1;
                    end
                end
            end

            HOLD: begin
                if (bus.start) begin
                    state_d  = RUN;
                    score_d  = '0;
                    misses_d = '0;
                    led_d    = '0;
                    timer_d  = '0;
                end
            end

            OVER: begin
                led_d  = '0;
                over_d = 1'b1;
                if (!bus.start) begin
                    state_d = HOLD;
                    over_d  = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; every output comes straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            led_q    <= '0;
            score_q  <= '0;
            misses_q <= '0;
            over_q   <= 1'b0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            led_q    <= led_d;
            score_q  <= score_d;
            misses_q <= misses_d;
            over_q   <= over_d;
            timer_q  <= timer_d;
        end
    end

    assign bus.led       = led_q;
    assign bus.score     = score_q;
    assign bus.misses    = misses_q;
    assign bus.game_over = over_q;
    assign bus.state_o   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_led_target_scorer.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_target_scorer
// Description : Directed self-checking bench for led_target_scorer with
//               NUM_LEDS=3, SCORE_W=3, TIMEOUT_CYC=4, MAX_MISSES=2.
//               Expected values follow WRONG_PENALTY_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_target_scorer;

    localparam int NUM_LEDS    = 3;
    localparam int SEL_W       = 2;
    localparam int SCORE_W     = 3;
    localparam int MISS_W      = 4;
    localparam int TIMEOUT_CYC = 4;
    localparam int MAX_MISSES  = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    led_target_scorer_if #(
        .NUM_LEDS (NUM_LEDS),
        .SEL_W    (SEL_W),
        .SCORE_W  (SCORE_W),
        .MISS_W   (MISS_W)
    ) bus ();

    led_target_scorer #(
        .NUM_LEDS    (NUM_LEDS),
        .SEL_W       (SEL_W),
        .SCORE_W     (SCORE_W),
        .MISS_W      (MISS_W),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .MAX_MISSES  (MAX_MISSES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one cycle of change/sel/btn, then sample 1 time unit after the edge.
    task automatic cyc(input logic c, input logic [1:0] sel, input logic [2:0] b);
        bus.change   = c;
        bus.rand_sel = sel;
        bus.btn      = b;
        @(posedge clk);
        #1;
        bus.change = 1'b0;
        bus.btn    = '0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 3'b000);
    endtask

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.change   = 1'b0;
        bus.rand_sel = '0;
        bus.btn      = '0;
        #12;
        check("rst_led",    32'(bus.led),       0);
        check("rst_score",  32'(bus.score),     0);
        check("rst_misses", 32'(bus.misses),    0);
        check("rst_over",   32'(bus.game_over), 0);
        check("rst_state",  32'(bus.state_o),   0);
        @(negedge clk);
        rst = 1'b0;

        // IDLE ignores change while start is low.
        cyc(1'b1, 2'd1, 3'b000);
        check("idle_state", 32'(bus.state_o), 0);
        check("idle_led",   32'(bus.led),     0);

        // Start and a simple hit.
        bus.start = 1'b1;
        cyc(1'b0, 2'd0, 3'b000);
        check("run_state", 32'(bus.state_o), 1);
        cyc(1'b1, 2'd2, 3'b000);
        check("load_led2", 32'(bus.led), 32'b100);
        cyc(1'b0, 2'd0, 3'b100);
        check("hit_score", 32'(bus.score), 1);
        check("hit_led",   32'(bus.led),   0);

        // Out-of-range select and replacement.
        cyc(1'b1, 2'd3, 3'b000);
        check("oor_led",    32'(bus.led),    0);
        check("oor_misses", 32'(bus.misses), 0);
        cyc(1'b1, 2'd0, 3'b000);
        check("load_led0", 32'(bus.led), 32'b001);
        cyc(1'b1, 2'd1, 3'b000);
        check("repl_led",    32'(bus.led),    32'b010);
        check("repl_misses", 32'(bus.misses), 1);
        cyc(1'b0, 2'd0, 3'b010);
        check("hit2_score", 32'(bus.score), 2);

        // Simultaneous hit and change: credit, reload, no miss; then saturate.
        cyc(1'b1, 2'd0, 3'b000);
        cyc(1'b1, 2'd2, 3'b001);
        check("sim_score",  32'(bus.score),  3);
        check("sim_led",    32'(bus.led),    32'b100);
        check("sim_misses", 32'(bus.misses), 1);
        cyc(1'b1, 2'd0, 3'b100);
        cyc(1'b1, 2'd1, 3'b001);
        cyc(1'b1, 2'd2, 3'b010);
        cyc(1'b1, 2'd0, 3'b100);
        check("score7", 32'(bus.score), 7);
        cyc(1'b1, 2'd1, 3'b001);
        check("sat_score",  32'(bus.score),  7);
        check("sat_led",    32'(bus.led),    32'b010);
        check("sat_misses", 32'(bus.misses), 1);
        // Several buttons at once on a lit target is still a single hit.
        cyc(1'b0, 2'd0, 3'b111);
        check("multi_led",    32'(bus.led),    0);
        check("multi_misses", 32'(bus.misses), 1);

        // start=0 wins over hit and change in the same cycle.
        cyc(1'b1, 2'd0, 3'b000);
        bus.start = 1'b0;
        cyc(1'b1, 2'd2, 3'b001);
        check("stop_state",  32'(bus.state_o), 2);
        check("stop_led",    32'(bus.led),     0);
        check("stop_score",  32'(bus.score),   7);
        check("stop_misses", 32'(bus.misses),  1);
        bus.start = 1'b1;
        cyc(1'b1, 2'd1, 3'b000);
        check("resume_state",  32'(bus.state_o), 1);
        check("resume_score",  32'(bus.score),   0);
        check("resume_misses", 32'(bus.misses),  0);
        check("resume_led",    32'(bus.led),     0);

        // Timeout: a target lasts four cycles; second expiry ends the round.
        cyc(1'b1, 2'd0, 3'b000);
        idle_cycles(3);
        check("tmo1_still_lit", 32'(bus.led), 32'b001);
        idle_cycles(1);
        check("tmo1_led",    32'(bus.led),     0);
        check("tmo1_misses", 32'(bus.misses),  1);
        check("tmo1_state",  32'(bus.state_o), 1);
        cyc(1'b1, 2'd1, 3'b000);
        idle_cycles(3);
        check("tmo2_still_lit", 32'(bus.led), 32'b010);
        idle_cycles(1);
        check("over_state",  32'(bus.state_o),   3);
        check("over_flag",   32'(bus.game_over), 1);
        check("over_misses", 32'(bus.misses),    2);
        check("over_led",    32'(bus.led),       0);
        cyc(1'b1, 2'd0, 3'b001);
        check("over_frozen_led",   32'(bus.led),     0);
        check("over_frozen_score", 32'(bus.score),   0);
        check("over_frozen_state", 32'(bus.state_o), 3);
        bus.start = 1'b0;
        cyc(1'b0, 2'd0, 3'b000);
        check("over_hold_state", 32'(bus.state_o),   2);
        check("over_hold_flag",  32'(bus.game_over), 0);
        check("over_hold_miss",  32'(bus.misses),    2);
        bus.start = 1'b1;
        cyc(1'b0, 2'd0, 3'b000);
        check("restart_misses", 32'(bus.misses), 0);
        check("restart_score",  32'(bus.score),  0);

        // Wrong press on a lit target.
        cyc(1'b1, 2'd0, 3'b000);
        cyc(1'b0, 2'd0, 3'b001);
        cyc(1'b1, 2'd0, 3'b000);
        cyc(1'b0, 2'd0, 3'b010);
`ifdef WRONG_PENALTY_EN
        check("wrong1_score",  32'(bus.score),  0);
        check("wrong1_misses", 32'(bus.misses), 1);
`else
        check("wrong1_score",  32'(bus.score),  1);
        check("wrong1_misses", 32'(bus.misses), 0);
`endif
        check("wrong1_led", 32'(bus.led), 32'b001);
        cyc(1'b0, 2'd0, 3'b010);
`ifdef WRONG_PENALTY_EN
        check("wrong2_score", 32'(bus.score),   0);
        check("wrong2_state", 32'(bus.state_o), 3);
`else
        check("wrong2_score", 32'(bus.score),   1);
        check("wrong2_state", 32'(bus.state_o), 1);
`endif

        // Async reset mid-round with score=5.
        bus.start = 1'b0;
        cyc(1'b0, 2'd0, 3'b000);
        bus.start = 1'b1;
        cyc(1'b0, 2'd0, 3'b000);
        cyc(1'b1, 2'd0, 3'b000);
        for (int i = 0; i < 5; i++) cyc(1'b1, 2'd0, 3'b001);
        check("pre_rst_score", 32'(bus.score), 5);
        #2;
        rst = 1'b1;
        #1;
        check("arst_led",    32'(bus.led),       0);
        check("arst_score",  32'(bus.score),     0);
        check("arst_misses", 32'(bus.misses),    0);
        check("arst_over",   32'(bus.game_over), 0);
        check("arst_state",  32'(bus.state_o),   0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
